item_store: RTL and testbench

Per-item storage for the vending datapath. Holds cost, stock count and sold count for up to `NUM_ITEMS` items. It sits directly downstream of the main control FSM:
- serves its item lookups with a fixed one-cycle latency;
- applies its dispense-update pulses (stock decrement, sold increment);
- while the machine is in configuration mode, accepts item programming and readback from the configuration interface.

---
 rtl/item_store.sv | 151 +++++++++++++++
 tb/tb_item_store.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/item_store.sv
// -----------------------------------------------------------------------------
// item_store
//
// Per-item storage for the vending datapath: cost, stock count and sold count
// for NUM_ITEMS entries. Serves one-cycle lookups and dispense updates in vend
// mode, and programming/readback in configuration mode.
//
// Ports:
//   clk, rstn              clock, asynchronous active-low reset
//   cfg_mode               1 = configuration mode (vend ports ignored)
//   cfg_wr_en/cfg_rd_en    program / read back entry at cfg_addr
//   cfg_addr, cfg_cost, cfg_avail   configuration address and write data
//   cfg_rd_valid, cfg_rd_cost, cfg_rd_avail, cfg_rd_sold   readback result
//   mem_read_en, mem_read_addr      vend lookup request
//   mem_data_valid, mem_item_cost, mem_item_available      lookup result
//   mem_update_en, mem_update_addr  dispense update (stock-1, sold+1)
// -----------------------------------------------------------------------------
module item_store #(
  parameter int NUM_ITEMS = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cfg_mode,
  input  logic        cfg_wr_en,
  input  logic        cfg_rd_en,
  input  logic [9:0]  cfg_addr,
  input  logic [15:0] cfg_cost,
  input  logic [7:0]  cfg_avail,
  output logic        cfg_rd_valid,
  output logic [15:0] cfg_rd_cost,
  output logic [7:0]  cfg_rd_avail,
  output logic [15:0] cfg_rd_sold,
  input  logic        mem_read_en,
  input  logic [9:0]  mem_read_addr,
  output logic [15:0] mem_item_cost,
  output logic [7:0]  mem_item_available,
  output logic        mem_data_valid,
  input  logic        mem_update_en,
  input  logic [9:0]  mem_update_addr
);

  // Entry storage. Held in flops because reset must clear every entry.
  logic [15:0] cost_q  [NUM_ITEMS];
  logic [7:0]  avail_q [NUM_ITEMS];
  logic [15:0] sold_q  [NUM_ITEMS];
  logic [15:0] cost_d  [NUM_ITEMS];
  logic [7:0]  avail_d [NUM_ITEMS];
  logic [15:0] sold_d  [NUM_ITEMS];

  // Mode gating: each port group only acts in its own mode.
  logic cfg_wr_fire, cfg_rd_fire, mem_rd_fire, mem_upd_fire;
  assign cfg_wr_fire  = cfg_mode  & cfg_wr_en;
  assign cfg_rd_fire  = cfg_mode  & cfg_rd_en;
  assign mem_rd_fire  = ~cfg_mode & mem_read_en;
  assign mem_upd_fire = ~cfg_mode & mem_update_en;

  // Next-state for the entries. Out-of-range addresses never match an index,
  // so writes and updates to them fall through with no effect.
  always_comb begin
    cost_d  = cost_q;
    avail_d = avail_q;
    sold_d  = sold_q;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (cfg_wr_fire && (cfg_addr == 10'(i))) begin
        cost_d[i]  = cfg_cost;
        avail_d[i] = cfg_avail;
        sold_d[i]  = 16'h0000;
      end else if (mem_upd_fire && (mem_update_addr == 10'(i))) begin
        avail_d[i] = (avail_q[i] == 8'h00)    ? 8'h00    : avail_q[i] - 8'h01;
        sold_d[i]  = (sold_q[i]  == 16'hFFFF) ? 16'hFFFF : sold_q[i] + 16'h0001;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
        cost_q[i]  <= 16'h0000;
        avail_q[i] <= 8'h00;
        sold_q[i]  <= 16'h0000;
      end
    end else begin
      cost_q  <= cost_d;
      avail_q <= avail_d;
      sold_q  <= sold_d;
    end
  end

  // Read muxes look at the current (pre-edge) contents, which gives read-old
  // behaviour for same-cycle lookup/update and readback/write collisions.
  // Unmatched addresses return cost=FFFF, avail=0, sold=0.
  logic [15:0] look_cost, rb_cost, rb_sold;
  logic [7:0]  look_avail, rb_avail;

  always_comb begin
    look_cost  = 16'hFFFF;
    look_avail = 8'h00;
    rb_cost    = 16'hFFFF;
    rb_avail   = 8'h00;
    rb_sold    = 16'h0000;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (mem_read_addr == 10'(i)) begin
        look_cost  = cost_q[i];
        look_avail = avail_q[i];
      end
      if (cfg_addr == 10'(i)) begin
        rb_cost  = cost_q[i];
        rb_avail = avail_q[i];
        rb_sold  = sold_q[i];
      end
    end
  end

  // Output registers: valids pulse for one cycle, data holds between pulses.
  logic        mem_valid_q, cfg_valid_q;
  logic [15:0] mem_cost_q, cfg_cost_q, cfg_sold_q;
  logic [7:0]  mem_avail_q, cfg_avail_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_valid_q <= 1'b0;
      mem_cost_q  <= 16'h0000;
      mem_avail_q <= 8'h00;
      cfg_valid_q <= 1'b0;
      cfg_cost_q  <= 16'h0000;
      cfg_avail_q <= 8'h00;
      cfg_sold_q  <= 16'h0000;
    end else begin
      mem_valid_q <= mem_rd_fire;
      cfg_valid_q <= cfg_rd_fire;
      if (mem_rd_fire) begin
        mem_cost_q  <= look_cost;
        mem_avail_q <= look_avail;
      end
      if (cfg_rd_fire) begin
        cfg_cost_q  <= rb_cost;
        cfg_avail_q <= rb_avail;
        cfg_sold_q  <= rb_sold;
      end
    end
  end

  assign mem_data_valid     = mem_valid_q;
  assign mem_item_cost      = mem_cost_q;
  assign mem_item_available = mem_avail_q;
  assign cfg_rd_valid       = cfg_valid_q;
  assign cfg_rd_cost        = cfg_cost_q;
  assign cfg_rd_avail       = cfg_avail_q;
  assign cfg_rd_sold        = cfg_sold_q;

endmodule

// File: tb/tb_item_store.sv
// -----------------------------------------------------------------------------
// tb_item_store
//
// Directed testbench for item_store (NUM_ITEMS = 16). Stimulus pushes the
// expected lookup/readback results into queues; a monitor on the falling edge
// pops and compares whenever a valid pulse appears, including the cycle in
// which it arrives.
// -----------------------------------------------------------------------------
module tb_item_store;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cfg_mode, cfg_wr_en, cfg_rd_en;
  logic [9:0]  cfg_addr;
  logic [15:0] cfg_cost;
  logic [7:0]  cfg_avail;
  logic        cfg_rd_valid;
  logic [15:0] cfg_rd_cost, cfg_rd_sold;
  logic [7:0]  cfg_rd_avail;
  logic        mem_read_en;
  logic [9:0]  mem_read_addr;
  logic [15:0] mem_item_cost;
  logic [7:0]  mem_item_available;
  logic        mem_data_valid;
  logic        mem_update_en;
  logic [9:0]  mem_update_addr;

  item_store #(.NUM_ITEMS(16)) dut (
    .clk                (clk),
    .rstn               (rstn),
    .cfg_mode           (cfg_mode),
    .cfg_wr_en          (cfg_wr_en),
    .cfg_rd_en          (cfg_rd_en),
    .cfg_addr           (cfg_addr),
    .cfg_cost           (cfg_cost),
    .cfg_avail          (cfg_avail),
    .cfg_rd_valid       (cfg_rd_valid),
    .cfg_rd_cost        (cfg_rd_cost),
    .cfg_rd_avail       (cfg_rd_avail),
    .cfg_rd_sold        (cfg_rd_sold),
    .mem_read_en        (mem_read_en),
    .mem_read_addr      (mem_read_addr),
    .mem_item_cost      (mem_item_cost),
    .mem_item_available (mem_item_available),
    .mem_data_valid     (mem_data_valid),
    .mem_update_en      (mem_update_en),
    .mem_update_addr    (mem_update_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] cost;
    logic [7:0]  avail;
    int          due;
  } mem_exp_t;

  typedef struct {
    logic [15:0] cost;
    logic [7:0]  avail;
    logic [15:0] sold;
    int          due;
  } cfg_exp_t;

  mem_exp_t mem_q[$];
  cfg_exp_t cfg_q[$];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every valid pulse against the oldest expectation.
  always @(negedge clk) begin
    if (mem_data_valid === 1'b1) begin
      if (mem_q.size() == 0) begin
        chk("mem_unexpected_pulse", 64'(mem_data_valid), 64'd0);
      end else begin
        mem_exp_t e;
        e = mem_q.pop_front();
        chk("mem_latency", 64'(cyc), 64'(e.due));
        chk("mem_cost", 64'(mem_item_cost), 64'(e.cost));
        chk("mem_avail", 64'(mem_item_available), 64'(e.avail));
        $display("lookup  cyc=%0d cost=%0h avail=%0d", cyc, mem_item_cost, mem_item_available);
      end
    end
    if (cfg_rd_valid === 1'b1) begin
      if (cfg_q.size() == 0) begin
        chk("cfg_unexpected_pulse", 64'(cfg_rd_valid), 64'd0);
      end else begin
        cfg_exp_t e;
        e = cfg_q.pop_front();
        chk("cfg_latency", 64'(cyc), 64'(e.due));
        chk("cfg_cost", 64'(cfg_rd_cost), 64'(e.cost));
        chk("cfg_avail", 64'(cfg_rd_avail), 64'(e.avail));
        chk("cfg_sold", 64'(cfg_rd_sold), 64'(e.sold));
        $display("readbk  cyc=%0d cost=%0h avail=%0d sold=%0d", cyc, cfg_rd_cost, cfg_rd_avail, cfg_rd_sold);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    mem_read_en   = 1'b0;
    mem_update_en = 1'b0;
    cfg_wr_en     = 1'b0;
    cfg_rd_en     = 1'b0;
  endtask

  task automatic push_mem(input logic [15:0] c, input logic [7:0] a);
    mem_q.push_back('{cost: c, avail: a, due: cyc + 1});
  endtask

  task automatic push_cfg(input logic [15:0] c, input logic [7:0] a, input logic [15:0] s);
    cfg_q.push_back('{cost: c, avail: a, sold: s, due: cyc + 1});
  endtask

  task automatic lookup(input logic [9:0] addr, input logic [15:0] c, input logic [7:0] a);
    cfg_mode      = 1'b0;
    mem_read_en   = 1'b1;
    mem_read_addr = addr;
    push_mem(c, a);
    step();
    clr();
  endtask

  task automatic cfg_write(input logic [9:0] addr, input logic [15:0] c, input logic [7:0] a);
    cfg_mode  = 1'b1;
    cfg_wr_en = 1'b1;
    cfg_addr  = addr;
    cfg_cost  = c;
    cfg_avail = a;
    step();
    clr();
  endtask

  task automatic cfg_read(input logic [9:0] addr, input logic [15:0] c, input logic [7:0] a,
                          input logic [15:0] s);
    cfg_mode  = 1'b1;
    cfg_rd_en = 1'b1;
    cfg_addr  = addr;
    push_cfg(c, a, s);
    step();
    clr();
  endtask

  task automatic update(input logic [9:0] addr, input int n);
    cfg_mode = 1'b0;
    for (int k = 0; k < n; k++) begin
      mem_update_en   = 1'b1;
      mem_update_addr = addr;
      step();
      clr();
    end
  endtask

  initial begin
    rstn            = 1'b0;
    cfg_mode        = 1'b0;
    cfg_addr        = '0;
    cfg_cost        = '0;
    cfg_avail       = '0;
    mem_read_addr   = '0;
    mem_update_addr = '0;
    clr();

    // Outputs during reset.
    #12;
    chk("rst_mem_outputs", 64'({mem_data_valid, mem_item_cost, mem_item_available}), 64'd0);
    chk("rst_cfg_outputs", 64'({cfg_rd_valid, cfg_rd_cost, cfg_rd_avail, cfg_rd_sold}), 64'd0);
    step();
    rstn = 1'b1;
    step();

    // Reset defaults.
    lookup(10'd3, 16'd0, 8'd0);

    // Program and lookup.
    cfg_write(10'd5, 16'd150, 8'd2);
    lookup(10'd5, 16'd150, 8'd2);

    // Lookup and update in config mode are ignored (no pulse, no change).
    cfg_mode        = 1'b1;
    mem_read_en     = 1'b1;
    mem_read_addr   = 10'd5;
    mem_update_en   = 1'b1;
    mem_update_addr = 10'd5;
    step();
    clr();
    step();
    lookup(10'd5, 16'd150, 8'd2);

    // Dispense saturation: avail 2 -> 1 -> 0 -> 0, sold 3.
    update(10'd5, 3);
    lookup(10'd5, 16'd150, 8'd0);
    cfg_read(10'd5, 16'd150, 8'd0, 16'd3);

    // Collision: read-old, update still applied, visible next cycle.
    cfg_write(10'd7, 16'd25, 8'd4);
    cfg_mode        = 1'b0;
    mem_read_en     = 1'b1;
    mem_read_addr   = 10'd7;
    mem_update_en   = 1'b1;
    mem_update_addr = 10'd7;
    push_mem(16'd25, 8'd4);
    step();
    clr();
    lookup(10'd7, 16'd25, 8'd3);
    cfg_read(10'd7, 16'd25, 8'd3, 16'd1);

    // Out-of-range lookups, back to back.
    lookup(10'd16, 16'hFFFF, 8'd0);
    lookup(10'd1023, 16'hFFFF, 8'd0);

    // Out-of-range config write must not alias onto any entry.
    cfg_write(10'd16, 16'd1234, 8'd9);
    cfg_read(10'd0, 16'd0, 8'd0, 16'd0);
    cfg_read(10'd15, 16'd0, 8'd0, 16'd0);
    cfg_read(10'd16, 16'hFFFF, 8'd0, 16'd0);

    // Reprogram and readback.
    cfg_write(10'd2, 16'd40, 8'd20);
    update(10'd2, 10);
    cfg_read(10'd2, 16'd40, 8'd10, 16'd10);
    cfg_mode  = 1'b1;
    cfg_wr_en = 1'b1;
    cfg_rd_en = 1'b1;
    cfg_addr  = 10'd2;
    cfg_cost  = 16'd90;
    cfg_avail = 8'd8;
    push_cfg(16'd40, 8'd10, 16'd10);
    step();
    clr();
    cfg_read(10'd2, 16'd90, 8'd8, 16'd0);

    // Config write/read in vend mode are ignored.
    cfg_mode  = 1'b0;
    cfg_wr_en = 1'b1;
    cfg_rd_en = 1'b1;
    cfg_addr  = 10'd3;
    cfg_cost  = 16'd7;
    cfg_avail = 8'd7;
    step();
    clr();
    lookup(10'd3, 16'd0, 8'd0);

    // Mode change right after an accepted lookup: pulse still arrives.
    lookup(10'd2, 16'd90, 8'd8);
    cfg_mode = 1'b1;
    step();

    // Reset while a lookup is pending: pulse dropped, outputs and entries cleared.
    cfg_mode      = 1'b0;
    mem_read_en   = 1'b1;
    mem_read_addr = 10'd2;
    @(negedge clk);
    #1;
    rstn = 1'b0;
    #1;
    chk("async_rst_mem_outputs", 64'({mem_data_valid, mem_item_cost, mem_item_available}), 64'd0);
    chk("async_rst_cfg_outputs", 64'({cfg_rd_valid, cfg_rd_cost, cfg_rd_avail, cfg_rd_sold}), 64'd0);
    step();
    clr();
    rstn = 1'b1;
    step();
    lookup(10'd2, 16'd0, 8'd0);
    cfg_read(10'd2, 16'd0, 8'd0, 16'd0);

    // Drain and confirm every expected pulse arrived.
    step();
    step();
    step();
    chk("mem_pending_left", 64'(mem_q.size()), 64'd0);
    chk("cfg_pending_left", 64'(cfg_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
